// File: rtl/barrier_lane.sv
// Approaching-obstacle sprite for one road lane: a start/abort/done run that advances
// the sprite once per frame, with perspective stretch stages and a hit window.
module barrier_lane #(
  parameter int          DIR      = 0,
  parameter int          START_X  = 458,
  parameter int          START_Y  = 360,
  parameter int          STEP_X   = 10,
  parameter int          STEP_Y   = 10,
  parameter int          END_Y    = 720,
  parameter int          STAGE1_Y = 440,
  parameter int          STAGE2_Y = 550,
  parameter int          HIT_LO   = 600,
  parameter int          HIT_HI   = 680,
  parameter int          X_MAX    = 1279,
  parameter logic [23:0] BODY_RGB = 24'hFF0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  input  logic        i_v_sync,
  input  logic        i_start,
  input  logic        i_abort,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue,
  output logic        o_sprite_hit,
  output logic        o_in_position,
  output logic        o_busy,
  output logic        o_done,
  output logic [1:0]  o_stage
);

  localparam logic [15:0] SX     = 16'(START_X);
  localparam logic [15:0] SY     = 16'(START_Y);
  localparam logic [15:0] STX16  = 16'(STEP_X);
  localparam logic [16:0] STX17  = 17'(STEP_X);
  localparam logic [16:0] STY17  = 17'(STEP_Y);
  localparam logic [16:0] ENDY17 = 17'(END_Y);
  localparam logic [15:0] ST1    = 16'(STAGE1_Y);
  localparam logic [15:0] ST2    = 16'(STAGE2_Y);
  localparam logic [15:0] HLO    = 16'(HIT_LO);
  localparam logic [15:0] HHI    = 16'(HIT_HI);
  localparam logic [15:0] XMAX16 = 16'(X_MAX);
  localparam logic [16:0] XMAX17 = 17'(X_MAX);

  typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] x, y, x_nxt, y_nxt;
  logic [1:0]  stage, stage_nxt;
  logic [2:0]  vs_pipe;
  logic        frame_tick;
  logic [15:0] x_step;
  logic [16:0] y_step;

  // v_sync crosses in through two flops; the third flop only remembers the last level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vs_pipe <= '0;
    else          vs_pipe <= {vs_pipe[1:0], i_v_sync};
  end

  assign frame_tick = vs_pipe[1] & ~vs_pipe[2];

  generate
    if (DIR == 0) begin : g_dec
      assign x_step = (x < STX16) ? '0 : x - STX16;
    end else if (DIR == 1) begin : g_inc
      logic [16:0] sum;
      assign sum    = {1'b0, x} + STX17;
      assign x_step = (sum > XMAX17) ? XMAX16 : sum[15:0];
    end else begin : g_hold
      assign x_step = x;
    end
  endgenerate

  assign y_step = {1'b0, y} + STY17;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      x     <= SX;
      y     <= SY;
      stage <= 2'd0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      stage <= stage_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    case (state)
      IDLE: begin
        x_nxt = SX;
        y_nxt = SY;
        if (i_start && !i_abort) state_nxt = MOVE;
      end
      MOVE: begin
        if (i_abort) begin
          state_nxt = IDLE;
          x_nxt     = SX;
          y_nxt     = SY;
        end else if (frame_tick) begin
          // the final step is not committed; the sprite leaves from its last drawn spot
          if (y_step >= ENDY17) begin
            state_nxt = DONE;
          end else begin
            x_nxt = x_step;
            y_nxt = y_step[15:0];
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        x_nxt     = SX;
        y_nxt     = SY;
      end
      default: begin
        state_nxt = IDLE;
        x_nxt     = SX;
        y_nxt     = SY;
      end
    endcase
  end

  always_comb begin
    if (y_nxt >= ST2)      stage_nxt = 2'd2;
    else if (y_nxt >= ST1) stage_nxt = 2'd1;
    else                   stage_nxt = 2'd0;
  end

  // Geometry is evaluated in 17 bits so the right/bottom edges cannot wrap past 16'hFFFF
  logic [16:0] px, py, xl, yl, width;
  logic [4:0]  dy;
  logic        in_box, opaque, hit;

  assign px     = {1'b0, i_x};
  assign py     = {1'b0, i_y};
  assign xl     = {1'b0, x};
  assign yl     = {1'b0, y};
  assign width  = 17'd64 << stage;
  assign in_box = (px >= xl) && (px < xl + width) && (py >= yl) && (py < yl + 17'd32);

  // Height is 32, so the low five bits of i_y - y give the in-box row offset; rows 3..6 are solid
  assign dy     = i_y[4:0] - y[4:0];
  assign opaque = (dy >= 5'd12) && (dy < 5'd28);
  assign hit    = (state == MOVE) && in_box && opaque;

  assign o_sprite_hit              = hit;
  assign {o_red, o_green, o_blue}  = hit ? BODY_RGB : 24'h0;
  assign o_in_position             = (state == MOVE) && (y >= HLO) && (y <= HHI);
  assign o_busy                    = (state == MOVE);
  assign o_done                    = (state == DONE);
  assign o_stage                   = stage;

endmodule

// File: tb/tb_barrier_lane.sv
// Bench for barrier_lane: three lanes (left, right near the edge, left near zero)
// checked every cycle against a tick-count model, plus hand-computed spot checks.
module tb_barrier_lane;

  logic        i_clk, i_rst_n, i_v_sync, i_start, i_abort;
  logic [15:0] i_x, i_y;

  logic [7:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic       hit0, hit1, hit2, pos0, pos1, pos2, busy0, busy1, busy2, done0, done1, done2;
  logic [1:0] stg0, stg1, stg2;

  barrier_lane #(.DIR(0), .START_X(458)) u0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y), .i_v_sync(i_v_sync),
    .i_start(i_start), .i_abort(i_abort), .o_red(r0), .o_green(g0), .o_blue(b0),
    .o_sprite_hit(hit0), .o_in_position(pos0), .o_busy(busy0), .o_done(done0), .o_stage(stg0));

  barrier_lane #(.DIR(1), .START_X(1270)) u1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y), .i_v_sync(i_v_sync),
    .i_start(i_start), .i_abort(i_abort), .o_red(r1), .o_green(g1), .o_blue(b1),
    .o_sprite_hit(hit1), .o_in_position(pos1), .o_busy(busy1), .o_done(done1), .o_stage(stg1));

  barrier_lane #(.DIR(0), .START_X(15)) u2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_x(i_x), .i_y(i_y), .i_v_sync(i_v_sync),
    .i_start(i_start), .i_abort(i_abort), .o_red(r2), .o_green(g2), .o_blue(b2),
    .o_sprite_hit(hit2), .o_in_position(pos2), .o_busy(busy2), .o_done(done2), .o_stage(stg2));

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a run is just "moving, n frames in"; everything visible follows from n.
  int mode;  // 0 idle, 1 moving, 2 done
  int n;
  logic h0, h1, h2;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode <= 0; n <= 0; h0 <= 1'b0; h1 <= 1'b0; h2 <= 1'b0;
    end else begin
      h0 <= i_v_sync; h1 <= h0; h2 <= h1;
      case (mode)
        2: begin mode <= 0; n <= 0; end
        0: if (i_start && !i_abort) begin mode <= 1; n <= 0; end
        default: begin
          if (i_abort) begin
            mode <= 0; n <= 0;
          end else if (h1 && !h2) begin
            if (360 + (n + 1) * 10 >= 720) mode <= 2;
            else n <= n + 1;
          end
        end
      endcase
    end
  end

  function automatic int ex_x(input int dir, input int sx, input int k);
    int v;
    if (dir == 0) begin v = sx - k * 10; if (v < 0) v = 0; end
    else begin v = sx + k * 10; if (v > 1279) v = 1279; end
    return v;
  endfunction

  function automatic int ex_y(input int k);
    return 360 + k * 10;
  endfunction

  function automatic int ex_stage(input int yy);
    return (yy >= 550) ? 2 : (yy >= 440) ? 1 : 0;
  endfunction

  function automatic logic ex_hit(input int dir, input int sx);
    int xx, yy, w, px, py;
    xx = ex_x(dir, sx, n); yy = ex_y(n); w = 64 << ex_stage(yy);
    px = int'(i_x); py = int'(i_y);
    return (mode == 1) && px >= xx && px < xx + w && py - yy >= 12 && py - yy < 28;
  endfunction

  task automatic cmp(input string nm, input int dir, input int sx, input logic busy,
                     input logic done, input logic [1:0] stg, input logic pos,
                     input logic hit, input logic [23:0] rgb);
    logic eh;
    int   yy;
    yy = ex_y(n);
    eh = ex_hit(dir, sx);
    chk({nm, ".busy"}, 32'(busy), 32'(mode == 1));
    chk({nm, ".done"}, 32'(done), 32'(mode == 2));
    chk({nm, ".stage"}, 32'(stg), 32'(ex_stage(yy)));
    chk({nm, ".in_pos"}, 32'(pos), 32'(mode == 1 && yy >= 600 && yy <= 680));
    chk({nm, ".hit"}, 32'(hit), 32'(eh));
    chk({nm, ".rgb"}, 32'(rgb), eh ? 32'hFF0000 : 32'h0);
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      cmp("u0", 0, 458, busy0, done0, stg0, pos0, hit0, {r0, g0, b0});
      cmp("u1", 1, 1270, busy1, done1, stg1, pos1, hit1, {r1, g1, b1});
      cmp("u2", 0, 15, busy2, done2, stg2, pos2, hit2, {r2, g2, b2});
    end
  end

  int done_cnt = 0;
  always @(negedge i_clk) if (i_rst_n && done0) done_cnt++;

  // Each cycle the pixel walks around the lane-0 sprite's edges and body rows
  int pr = 0;
  task automatic cyc();
    int xx, yy, w;
    @(posedge i_clk);
    #2;
    xx = ex_x(0, 458, n); yy = ex_y(n); w = 64 << ex_stage(yy);
    case (pr)
      0: begin i_x = 16'(xx + 4);     i_y = 16'(yy + 12); end
      1: begin i_x = 16'(xx + 4);     i_y = 16'(yy + 2);  end
      2: begin i_x = 16'(xx + w - 1); i_y = 16'(yy + 27); end
      3: begin i_x = 16'(xx + w);     i_y = 16'(yy + 12); end
      4: begin i_x = 16'(xx);         i_y = 16'(yy + 28); end
      default: begin i_x = 16'(xx - 1); i_y = 16'(yy + 12); end
    endcase
    pr = (pr + 1) % 6;
  endtask

  task automatic vpulse(input logic ab);
    i_v_sync = 1'b1;
    cyc(); cyc();
    i_v_sync = 1'b0;
    i_abort  = ab;
    cyc();
    i_abort  = 1'b0;
    cyc();
  endtask

  task automatic probe(input int px, input int py);
    i_x = 16'(px); i_y = 16'(py);
    #1;
  endtask

  int dc;
  initial begin
    i_rst_n = 1'b0; i_v_sync = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    i_x = 16'd462; i_y = 16'd372;
    #1;
    chk("reset.busy", 32'(busy0), 32'd0);
    chk("reset.hit", 32'(hit0), 32'd0);
    chk("reset.rgb", 32'({r0, g0, b0}), 32'd0);
    chk("reset.stage", 32'(stg0), 32'd0);
    chk("reset.done", 32'(done0), 32'd0);
    @(posedge i_clk); @(posedge i_clk); #2;
    i_rst_n = 1'b1;

    // idle lane ignores frames
    repeat (5) vpulse(1'b0);
    chk("idle.y", 32'(u0.y), 32'd360);
    chk("idle.busy", 32'(busy0), 32'd0);

    // left lane run
    i_start = 1'b1; cyc(); i_start = 1'b0;
    repeat (8) vpulse(1'b0);
    chk("t8.y", 32'(u0.y), 32'd440);
    chk("t8.x", 32'(u0.x), 32'd378);
    chk("t8.stage", 32'(stg0), 32'd1);
    probe(382, 452);
    chk("t8.hit_body", 32'(hit0), 32'd1);
    chk("t8.rgb_body", 32'({r0, g0, b0}), 32'hFF0000);
    probe(382, 442);
    chk("t8.hit_top", 32'(hit0), 32'd0);
    repeat (16) vpulse(1'b0);
    chk("t24.y", 32'(u0.y), 32'd600);
    chk("t24.x", 32'(u0.x), 32'd218);
    chk("t24.stage", 32'(stg0), 32'd2);
    chk("t24.in_pos", 32'(pos0), 32'd1);
    probe(222, 612);
    chk("t24.hit", 32'(hit0), 32'd1);
    repeat (9) vpulse(1'b0);
    chk("t33.in_pos", 32'(pos0), 32'd0);
    repeat (2) vpulse(1'b0);
    dc = done_cnt;
    i_start = 1'b1;
    vpulse(1'b0);
    chk("t36.done_pulses", 32'(done_cnt - dc), 32'd1);
    chk("t36.busy", 32'(busy0), 32'd0);
    chk("t36.x", 32'(u0.x), 32'd458);
    chk("t36.y", 32'(u0.y), 32'd360);
    cyc();
    chk("relaunch.busy", 32'(busy0), 32'd1);
    i_start = 1'b0;
    i_abort = 1'b1; cyc(); i_abort = 1'b0;
    cyc();

    // edge saturation
    i_start = 1'b1; cyc(); i_start = 1'b0;
    vpulse(1'b0);
    probe(1279, 382);
    chk("sat_hi.hit", 32'(hit1), 32'd1);
    probe(1278, 382);
    chk("sat_hi.miss", 32'(hit1), 32'd0);
    probe(5, 382);
    chk("sat_lo1.hit", 32'(hit2), 32'd1);
    probe(4, 382);
    chk("sat_lo1.miss", 32'(hit2), 32'd0);
    vpulse(1'b0);
    probe(0, 392);
    chk("sat_lo2.hit", 32'(hit2), 32'd1);
    chk("sat_lo2.x", 32'(u2.x), 32'd0);
    chk("sat_hi2.x", 32'(u1.x), 32'd1279);
    vpulse(1'b0);
    chk("sat_lo3.x", 32'(u2.x), 32'd0);

    // abort coinciding with a frame tick at y = 500
    repeat (11) vpulse(1'b0);
    chk("pre_abort.y", 32'(u0.y), 32'd500);
    dc = done_cnt;
    vpulse(1'b1);
    chk("abort.y", 32'(u0.y), 32'd360);
    chk("abort.busy", 32'(busy0), 32'd0);
    chk("abort.no_done", 32'(done_cnt - dc), 32'd0);

    i_start = 1'b1; i_abort = 1'b1; cyc(); cyc();
    i_start = 1'b0; i_abort = 1'b0;
    chk("start_abort.busy", 32'(busy0), 32'd0);

    // asynchronous reset mid-run
    i_start = 1'b1; cyc(); i_start = 1'b0;
    repeat (25) vpulse(1'b0);
    chk("pre_rst.in_pos", 32'(pos0), 32'd1);
    probe(212, 622);
    chk("pre_rst.hit", 32'(hit0), 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(busy0), 32'd0);
    chk("rst.in_pos", 32'(pos0), 32'd0);
    chk("rst.hit", 32'(hit0), 32'd0);
    chk("rst.rgb", 32'({r0, g0, b0}), 32'd0);
    chk("rst.stage", 32'(stg0), 32'd0);
    cyc(); cyc();
    i_rst_n = 1'b1;
    cyc(); cyc();
    chk("post_rst.busy", 32'(busy0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/barrier_lane.md
Name: barrier_lane

Overview:
- Parametrised approaching-obstacle sprite for the road scene, successor to the fixed left-lane barrier.
- One instance per lane, configured through `DIR` (left / right / straight).
- Runs a start/abort/done state machine clocked on the system clock rather than on `i_v_sync`.
- Provides configurable perspective stretch stages, a configurable hit window and deterministic (non-X) pixel outputs.
- Sits beside the other sprite generators; the colour mux and collision logic consume its outputs.

Parameters:
- `DIR`, 0, lane direction: 0 = x decreases per frame, 1 = x increases, 2 = x constant.
- `START_X`, 458, x of top-left corner at launch.
- `START_Y`, 360, y of top-left corner at launch.
- `STEP_X`, 10, x increment/decrement per frame (unsigned).
- `STEP_Y`, 10, y increment per frame.
- `END_Y`, 720, y at or beyond which the run completes.
- `STAGE1_Y`, 440, y at/above which width is 128 (shift 3); below this, width is 64 (shift 2).
- `STAGE2_Y`, 550, y at/above which width is 256 (shift 4).
- `HIT_LO`, 600, lower bound of the hit window (inclusive).
- `HIT_HI`, 680, upper bound of the hit window (inclusive).
- `X_MAX`, 1279, saturation limit for x.
- `BODY_RGB`, 24'hFF0000, colour of opaque rows.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset.
- `i_x`  in  16  current pixel x.
- `i_y`  in  16  current pixel y.
- `i_v_sync`  in  1  vertical sync, asynchronous to `i_clk`.
- `i_start`  in  1  launch request (level or pulse).
- `i_abort`  in  1  cancel the run.
- `o_red`  out  8  pixel red.
- `o_green`  out  8  pixel green.
- `o_blue`  out  8  pixel blue.
- `o_sprite_hit`  out  1  opaque pixel of an active barrier at (`i_x`, `i_y`).
- `o_in_position`  out  1  barrier inside the hit window.
- `o_busy`  out  1  run in progress.
- `o_done`  out  1  one-cycle pulse at natural completion.
- `o_stage`  out  2  current stretch stage (0/1/2).

Behaviour:
- Clock and reset: one clock `i_clk`; reset `i_rst_n` is asynchronous, active-low.
- Reset values:
  - State IDLE; x = `START_X`, y = `START_Y`; stage 0.
  - `o_busy`, `o_done`, `o_in_position`, `o_sprite_hit` = 0; `o_stage` = 0.
  - RGB outputs = 0.
  - Both sync FFs = 0.
- Frame tick:
  - `i_v_sync` passes through a 2-FF synchroniser.
  - `frame_tick` = 1 for one `i_clk` cycle on its rising edge (synced & ~prev).
  - Tick latency: 3 `i_clk` cycles from `i_v_sync` rising.
- State machine:
  - IDLE:
    - Not drawn; x/y held at start values.
    - `i_start` & ~`i_abort` → MOVE next cycle.
    - `i_abort` has priority over `i_start`.
  - MOVE:
    - `o_busy` = 1.
    - `i_start` is ignored (no restart).
    - On `frame_tick`: y ← y + `STEP_Y`; x per `DIR`.
    - `DIR` = 0: x ← x − `STEP_X`, saturating at 0.
    - `DIR` = 1: x ← x + `STEP_X`, saturating at `X_MAX`.
    - `DIR` = 2: x unchanged.
    - If the new y ≥ `END_Y`: go to DONE and do not update x/y that cycle.
    - `i_abort` → IDLE next cycle; x/y reset to start values; no `o_done`.
    - `i_abort` wins over `frame_tick` in the same cycle.
  - DONE:
    - Single cycle; `o_done` = 1; x/y reset to start values.
    - → IDLE unconditionally; `i_start` and `i_abort` are ignored in DONE.
- Stage (registered, updated with y):
  - stage = 2 if y ≥ `STAGE2_Y`, else 1 if y ≥ `STAGE1_Y`, else 0.
  - Width = 64 << stage; horizontal shift = 2 + stage.
- Sprite geometry:
  - 16 columns × 8 rows; height fixed at 32 pixels (row = (`i_y` − y) >> 2).
  - Column = (`i_x` − x) >> shift.
  - Rows 0–2 and 7 are transparent; rows 3–6 are `BODY_RGB`.
- Hit test: `in_box` = (`i_x` ≥ x) & (`i_x` < x + width) & (`i_y` ≥ y) & (`i_y` < y + 32).
  - Computed in 17 bits so x + width cannot wrap.
- Pixel outputs (combinational from `i_x`, `i_y` and registered state):
  - `o_sprite_hit` = (state == MOVE) & `in_box` & opaque row.
  - RGB = `BODY_RGB` bytes when `o_sprite_hit`, else 0 (never X).
- `o_in_position` = (state == MOVE) & (`HIT_LO` ≤ y ≤ `HIT_HI`); registered state, so it is glitch-free.
- Run length: ceil((`END_Y` − `START_Y`) / `STEP_Y`) frame ticks; 36 with the defaults.

Test Plan:
1. Reset released, no start, 5 `i_v_sync` pulses → y stays 360, `o_busy` = 0, `o_sprite_hit` = 0 everywhere, RGB = 0.
2. `DIR` = 0, start, 8 ticks → y = 440, x = 378, `o_stage` = 1.
   - Pixel (378+4, 440+12) → `o_sprite_hit` = 1, RGB = FF/00/00.
   - Pixel (378+4, 440+2) → `o_sprite_hit` = 0.
3. `DIR` = 0, start, 24 ticks → y = 600, x = 218, `o_stage` = 2, `o_in_position` = 1.
   - After 33 ticks (y = 690) `o_in_position` = 0.
4. Continue run to tick 36 → `o_done` high exactly one cycle, then IDLE with x = 458, y = 360, `o_busy` = 0.
   - An `i_start` held through DONE launches a new run from IDLE.
5. `DIR` = 1 with `START_X` = 1270 → x saturates at 1279 after the first tick; `DIR` = 0 with `START_X` = 15 → x = 5, then 0, then holds at 0.
6. Abort asserted in the same cycle as `frame_tick` at y = 500 → IDLE, y = 360, no `o_done`.
   - `i_start` and `i_abort` together in IDLE → stays IDLE.
   - `i_rst_n` low mid-run → all outputs 0 immediately, without waiting for a clock edge.
